// File: rtl/block_run_controller.sv
`timescale 1ns/1ps
// block_run_controller
//
// Run control and status aggregation for an array of NUM_TILES tiles.
// Distributes reset/enable/execute to the tiles through SYNC_STAGES
// registers, reduces per-tile halted/quiescent status through a masked
// AND tree followed by REDUCE_STAGES registers, and sequences a run:
// IDLE -> RUN -> DRAIN -> DONE, with an optional timeout and abort.
//
// Ports:
//   clock                    positive-edge clock
//   reset                    synchronous, active-low reset
//   enable                   global enable (registered; 0 freezes the run FSM)
//   execute                  run request, level sensitive (registered)
//   tile_mask                1 = tile participates, 0 = tile reads as halted/quiescent
//   timeout_limit            run-cycle timeout, 0 disables it
//   tile_halted              per-tile halted status
//   tile_channels_quiescent  per-tile channel quiescence
//   tile_routers_quiescent   per-tile router quiescence
//   tile_reset               active-high reset to the tiles
//   tile_enable              enable to the tiles
//   tile_execute             execute to the tiles (high while in RUN)
//   halted                   reduced halted status
//   channels_quiescent       reduced channel quiescence
//   routers_quiescent        reduced router quiescence
//   done                     run completed normally
//   timed_out                run aborted by timeout
//   run_cycles               cycles spent in RUN + DRAIN, saturating
module block_run_controller #(
  parameter int NUM_TILES           = 4,
  parameter int SYNC_STAGES         = 1,
  parameter int REDUCE_STAGES       = 1,
  parameter int CYCLE_COUNTER_WIDTH = 32,
  parameter int QUIESCENT_HOLD      = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           execute,
  input  logic [NUM_TILES-1:0]           tile_mask,
  input  logic [CYCLE_COUNTER_WIDTH-1:0] timeout_limit,
  input  logic [NUM_TILES-1:0]           tile_halted,
  input  logic [NUM_TILES-1:0]           tile_channels_quiescent,
  input  logic [NUM_TILES-1:0]           tile_routers_quiescent,
  output logic                           tile_reset,
  output logic                           tile_enable,
  output logic                           tile_execute,
  output logic                           halted,
  output logic                           channels_quiescent,
  output logic                           routers_quiescent,
  output logic                           done,
  output logic                           timed_out,
  output logic [CYCLE_COUNTER_WIDTH-1:0] run_cycles
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_DRAIN   = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  // Halted is ignored long enough for execute to reach the tiles and for
  // their fresh status to come back through the reduction pipeline.
  localparam int BLANK_CYCLES = SYNC_STAGES + REDUCE_STAGES + 1;
  localparam int BLANK_W      = $clog2(BLANK_CYCLES + 1);
  localparam int HOLD_W       = $clog2(QUIESCENT_HOLD + 1);
  localparam int CW           = CYCLE_COUNTER_WIDTH;

  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES - 1);
  localparam logic [BLANK_W-1:0] BLANK_ONE  = BLANK_W'(1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(QUIESCENT_HOLD - 1);
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
  localparam logic [CW-1:0]      CYCLE_ONE  = CW'(1);
  localparam logic [CW-1:0]      CYCLE_MAX  = '1;

  logic enable_q;
  logic execute_q;

  logic r_halted;
  logic r_channels;
  logic r_routers;

  logic [REDUCE_STAGES-1:0] halted_pipe;
  logic [REDUCE_STAGES-1:0] channels_pipe;
  logic [REDUCE_STAGES-1:0] routers_pipe;

  logic [SYNC_STAGES-1:0] reset_pipe;
  logic [SYNC_STAGES-1:0] enable_pipe;
  logic [SYNC_STAGES-1:0] execute_pipe;

  logic [2:0]         state;
  logic [2:0]         next_state;
  logic [BLANK_W-1:0] blank_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [CW:0]        run_cycles_plus;
  logic               timeout_hit;
  logic               all_quiescent;

  // Masked-out tiles contribute a 1 so they never block the AND.
  assign r_halted   = &(tile_halted             | ~tile_mask);
  assign r_channels = &(tile_channels_quiescent | ~tile_mask);
  assign r_routers  = &(tile_routers_quiescent  | ~tile_mask);

  assign halted             = halted_pipe[REDUCE_STAGES-1];
  assign channels_quiescent = channels_pipe[REDUCE_STAGES-1];
  assign routers_quiescent  = routers_pipe[REDUCE_STAGES-1];

  assign tile_reset   = reset_pipe[SYNC_STAGES-1];
  assign tile_enable  = enable_pipe[SYNC_STAGES-1];
  assign tile_execute = execute_pipe[SYNC_STAGES-1];

  assign all_quiescent = channels_quiescent & routers_quiescent;

  always_ff @(posedge clock) begin
    if (!reset) begin
      enable_q      <= 1'b0;
      execute_q     <= 1'b0;
      halted_pipe   <= '0;
      channels_pipe <= '0;
      routers_pipe  <= '0;
      reset_pipe    <= '1;
      enable_pipe   <= '0;
      execute_pipe  <= '0;
    end else begin
      enable_q         <= enable;
      execute_q        <= execute;
      halted_pipe[0]   <= r_halted;
      channels_pipe[0] <= r_channels;
      routers_pipe[0]  <= r_routers;
      for (int i = 1; i < REDUCE_STAGES; i++) begin
        halted_pipe[i]   <= halted_pipe[i-1];
        channels_pipe[i] <= channels_pipe[i-1];
        routers_pipe[i]  <= routers_pipe[i-1];
      end
      reset_pipe[0]   <= 1'b0;
      enable_pipe[0]  <= enable_q;
      execute_pipe[0] <= (state == ST_RUN);
      for (int i = 1; i < SYNC_STAGES; i++) begin
        reset_pipe[i]   <= reset_pipe[i-1];
        enable_pipe[i]  <= enable_pipe[i-1];
        execute_pipe[i] <= execute_pipe[i-1];
      end
    end
  end

  // The timeout compare is one bit wider so run_cycles+1 cannot wrap.
  assign run_cycles_plus = {1'b0, run_cycles} + {1'b0, CYCLE_ONE};
  assign timeout_hit     = (timeout_limit != '0) &&
                           (run_cycles_plus >= {1'b0, timeout_limit});

  // Timeout wins over abort, drain entry and drain completion.
  always_comb begin
    next_state = state;
    if (enable_q) begin
      case (state)
        ST_IDLE: begin
          if (execute_q) next_state = ST_RUN;
        end
        ST_RUN: begin
          if (timeout_hit)                         next_state = ST_TIMEOUT;
          else if (!execute_q)                     next_state = ST_IDLE;
          else if ((blank_cnt == '0) && halted)    next_state = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (timeout_hit)                         next_state = ST_TIMEOUT;
          else if (all_quiescent && (hold_cnt == HOLD_LAST))
                                                   next_state = ST_DONE;
        end
        ST_DONE, ST_TIMEOUT: begin
          if (!execute_q) next_state = ST_IDLE;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      run_cycles <= '0;
      blank_cnt  <= '0;
      hold_cnt   <= '0;
      done       <= 1'b0;
      timed_out  <= 1'b0;
    end else begin
      state     <= next_state;
      done      <= (next_state == ST_DONE);
      timed_out <= (next_state == ST_TIMEOUT);
      if (enable_q) begin
        if ((state == ST_IDLE) && (next_state == ST_RUN)) begin
          run_cycles <= '0;
          blank_cnt  <= BLANK_LOAD;
          hold_cnt   <= '0;
        end
        if (((state == ST_RUN) || (state == ST_DRAIN)) && (run_cycles != CYCLE_MAX)) begin
          run_cycles <= run_cycles + CYCLE_ONE;
        end
        if ((state == ST_RUN) && (blank_cnt != '0)) begin
          blank_cnt <= blank_cnt - BLANK_ONE;
        end
        if (state == ST_DRAIN) begin
          hold_cnt <= all_quiescent ? (hold_cnt + HOLD_ONE) : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_block_run_controller.sv
`timescale 1ns/1ps
// Testbench for block_run_controller: directed scenarios followed by a
// randomized phase, all checked every cycle against a behavioural model.
module tb_block_run_controller;

  localparam int NT    = 4;
  localparam int SS    = 1;
  localparam int RS    = 1;
  localparam int CW    = 32;
  localparam int QH    = 4;
  localparam int BLANK = SS + RS + 1;
  localparam longint MAXRC = (longint'(1) << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          execute;
  logic [NT-1:0] tile_mask;
  logic [CW-1:0] timeout_limit;
  logic [NT-1:0] tile_halted;
  logic [NT-1:0] tile_channels_quiescent;
  logic [NT-1:0] tile_routers_quiescent;
  logic          tile_reset;
  logic          tile_enable;
  logic          tile_execute;
  logic          halted;
  logic          channels_quiescent;
  logic          routers_quiescent;
  logic          done;
  logic          timed_out;
  logic [CW-1:0] run_cycles;

  int checks = 0;
  int passes = 0;

  block_run_controller #(
    .NUM_TILES(NT), .SYNC_STAGES(SS), .REDUCE_STAGES(RS),
    .CYCLE_COUNTER_WIDTH(CW), .QUIESCENT_HOLD(QH)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .execute(execute),
    .tile_mask(tile_mask), .timeout_limit(timeout_limit),
    .tile_halted(tile_halted),
    .tile_channels_quiescent(tile_channels_quiescent),
    .tile_routers_quiescent(tile_routers_quiescent),
    .tile_reset(tile_reset), .tile_enable(tile_enable), .tile_execute(tile_execute),
    .halted(halted), .channels_quiescent(channels_quiescent),
    .routers_quiescent(routers_quiescent),
    .done(done), .timed_out(timed_out), .run_cycles(run_cycles)
  );

  always #5 clock = ~clock;

  // Behavioural model: delay lines as queues (index 0 is what the tiles or
  // the FSM currently see), run phase tracked as a name.
  bit     m_en_q, m_ex_q;
  bit     hq[$], cq[$], rq[$];
  bit     tq[$], eq[$], xq[$];
  string  m_phase = "IDLE";
  longint m_rc;
  int     m_age, m_streak;
  bit     m_done, m_to;

  function automatic bit reduceStatus(input logic [NT-1:0] st, input logic [NT-1:0] mask);
    bit all_ok = 1'b1;
    for (int i = 0; i < NT; i++)
      if (mask[i] && !st[i]) all_ok = 1'b0;
    return all_ok;
  endfunction

  task automatic modelReset();
    hq.delete(); cq.delete(); rq.delete(); tq.delete(); eq.delete(); xq.delete();
    for (int i = 0; i < RS; i++) begin hq.push_back(0); cq.push_back(0); rq.push_back(0); end
    for (int i = 0; i < SS; i++) begin tq.push_back(1); eq.push_back(0); xq.push_back(0); end
    m_en_q = 0; m_ex_q = 0; m_phase = "IDLE"; m_rc = 0; m_age = 0; m_streak = 0;
    m_done = 0; m_to = 0;
  endtask

  task automatic modelStep();
    bit halt_o, quiet_o, was_run, to_hit;
    string nxt;
    if (!reset) begin
      modelReset();
      return;
    end
    halt_o  = hq[0];
    quiet_o = cq[0] && rq[0];
    was_run = (m_phase == "RUN");
    nxt     = m_phase;
    if (m_en_q) begin
      if (m_phase == "IDLE") begin
        if (m_ex_q) begin nxt = "RUN"; m_rc = 0; m_age = 1; m_streak = 0; end
      end else if (m_phase == "RUN" || m_phase == "DRAIN") begin
        to_hit = (timeout_limit != 0) && (m_rc + 1 >= longint'(timeout_limit));
        if (m_rc < MAXRC) m_rc = m_rc + 1;
        if (to_hit) nxt = "TIMEOUT";
        else if (m_phase == "RUN") begin
          if (!m_ex_q) nxt = "IDLE";
          else if (m_age >= BLANK && halt_o) begin nxt = "DRAIN"; m_streak = 0; end
          else m_age++;
        end else begin
          if (quiet_o) begin
            m_streak++;
            if (m_streak >= QH) nxt = "DONE";
          end else m_streak = 0;
        end
      end else begin
        if (!m_ex_q) nxt = "IDLE";
      end
    end
    m_phase = nxt;
    m_done  = (nxt == "DONE");
    m_to    = (nxt == "TIMEOUT");
    void'(hq.pop_front()); hq.push_back(reduceStatus(tile_halted, tile_mask));
    void'(cq.pop_front()); cq.push_back(reduceStatus(tile_channels_quiescent, tile_mask));
    void'(rq.pop_front()); rq.push_back(reduceStatus(tile_routers_quiescent, tile_mask));
    void'(tq.pop_front()); tq.push_back(1'b0);
    void'(eq.pop_front()); eq.push_back(m_en_q);
    void'(xq.pop_front()); xq.push_back(was_run);
    m_en_q = enable;
    m_ex_q = execute;
  endtask

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
  endtask

  // One clock: inputs are stable across the edge, outputs are sampled 1ns later.
  task automatic applyStimulus();
    @(posedge clock);
    modelStep();
    #1;
    checkOutput("tile_reset",   tile_reset,         tq[0]);
    checkOutput("tile_enable",  tile_enable,        eq[0]);
    checkOutput("tile_execute", tile_execute,       xq[0]);
    checkOutput("halted",       halted,             hq[0]);
    checkOutput("channels_q",   channels_quiescent, cq[0]);
    checkOutput("routers_q",    routers_quiescent,  rq[0]);
    checkOutput("done",         done,               m_done);
    checkOutput("timed_out",    timed_out,          m_to);
    checkOutput("run_cycles",   run_cycles,         m_rc);
  endtask

  task automatic stopRun();
    execute = 0; tile_halted = '0; timeout_limit = '0;
    repeat (4) applyStimulus();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt;
    int d;
    bit glitched;
    longint snap;

    reset = 0; enable = 0; execute = 0; tile_mask = '1; timeout_limit = '0;
    tile_halted = '0; tile_channels_quiescent = '1; tile_routers_quiescent = '1;

    // Reset defaults and tile_reset release timing
    repeat (3) applyStimulus();
    checkOutput("rst_tile_reset", tile_reset, 1);
    checkOutput("rst_tile_exec",  tile_execute, 0);
    checkOutput("rst_halted",     halted, 0);
    checkOutput("rst_done",       done, 0);
    checkOutput("rst_run_cycles", run_cycles, 0);
    reset = 1; enable = 1;
    for (int k = 1; k <= SS; k++) begin
      applyStimulus();
      checkOutput("tile_reset_release", tile_reset, (k < SS) ? 1 : 0);
    end
    repeat (3) applyStimulus();

    // Empty mask reads as halted and quiescent straight after reset
    tile_mask = '0; reset = 0;
    applyStimulus();
    reset = 1;
    repeat (RS) applyStimulus();
    checkOutput("mask0_halted",   halted, 1);
    checkOutput("mask0_channels", channels_quiescent, 1);
    checkOutput("mask0_routers",  routers_quiescent, 1);
    tile_mask = '1;
    repeat (3) applyStimulus();

    // Normal run: tiles halt 20 cycles after tile_execute rises
    execute = 1; cnt = 0;
    for (int i = 0; i < 200 && !m_done; i++) begin
      applyStimulus();
      if (xq[0]) cnt++;
      if (cnt >= 20) tile_halted = '1;
    end
    checkOutput("normal_done", done, 1);
    snap = m_rc;
    repeat (5) applyStimulus();
    checkOutput("normal_cycles_stable", run_cycles, snap);
    execute = 0;
    repeat (2) applyStimulus();
    checkOutput("normal_back_idle", done, 0);
    stopRun();

    // Tile 3 masked off and never halts; router quiescence glitches in DRAIN
    tile_mask = 4'b0111; execute = 1; cnt = 0; d = 0; glitched = 0;
    for (int i = 0; i < 200 && !m_done; i++) begin
      applyStimulus();
      if (xq[0]) cnt++;
      if (cnt >= 10) tile_halted = 4'b0111;
      if (m_phase == "DRAIN") d++;
      if (glitched && tile_routers_quiescent == '0) begin
        tile_routers_quiescent = '1;
        break;
      end
      if (d == 3 && !glitched) begin
        tile_routers_quiescent = '0;
        glitched = 1;
      end
    end
    cnt = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      applyStimulus();
      cnt++;
    end
    checkOutput("masked_done", done, 1);
    checkOutput("glitch_done_latency", cnt, QH + RS);
    stopRun();
    tile_mask = '1;

    // Stale halted at execute rise: RUN lasts exactly the blanking window
    tile_halted = '1;
    repeat (3) applyStimulus();
    execute = 1; cnt = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus();
      if (tile_execute) cnt++;
    end
    checkOutput("blank_run_length", cnt, BLANK);
    checkOutput("blank_done", done, 1);
    stopRun();

    // Timeout with tiles that never halt
    timeout_limit = 10; execute = 1;
    for (int i = 0; i < 100 && !m_to; i++) applyStimulus();
    checkOutput("timeout_flag",   timed_out, 1);
    checkOutput("timeout_cycles", run_cycles, 10);
    repeat (SS) applyStimulus();
    checkOutput("timeout_tile_exec", tile_execute, 0);
    stopRun();

    // Enable low freezes run_cycles
    execute = 1;
    repeat (8) applyStimulus();
    enable = 0;
    applyStimulus();
    snap = m_rc;
    repeat (5) begin
      applyStimulus();
      checkOutput("freeze_run_cycles", run_cycles, snap);
    end
    enable = 1;
    repeat (4) applyStimulus();
    stopRun();

    // Randomized traffic including mid-run resets
    for (int i = 0; i < 2500; i++) begin
      reset  = ($urandom_range(0, 199) != 0);
      enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 39) == 0) execute = ~execute;
      if ($urandom_range(0, 49) == 0) tile_mask = NT'($urandom);
      if ($urandom_range(0, 59) == 0)
        timeout_limit = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(3, 40));
      for (int t = 0; t < NT; t++) begin
        if ($urandom_range(0, 19) == 0) tile_halted[t] = ~tile_halted[t];
        tile_channels_quiescent[t] = ($urandom_range(0, 9) != 0);
        tile_routers_quiescent[t]  = ($urandom_range(0, 9) != 0);
      end
      applyStimulus();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/block_run_controller.md
# block_run_controller

Parametrised run-control and status-aggregation stage for a tile array of NUM_TILES tiles (quartets or blocks). Distributes reset, enable and execute to the tiles through a configurable register pipeline. Reduces per-tile halted/quiescent status through a masked, pipelined AND tree. Adds a run-state machine that the fixed-size array never had: run-cycle counting, halt-then-drain completion detection, and an optional timeout.

## Interface
Parameters:
- NUM_TILES, 4, number of tiles controlled (≥1)
- SYNC_STAGES, 1, register stages on tile_reset/tile_enable/tile_execute (≥1)
- REDUCE_STAGES, 1, register stages on each status reduction (≥1)
- CYCLE_COUNTER_WIDTH, 32, width of run_cycles and timeout_limit
- QUIESCENT_HOLD, 4, consecutive quiescent cycles required to finish draining (≥1)

Ports:
- clock  input  1  positive-edge clock
- reset  input  1  synchronous, active-low reset
- enable  input  1  global enable, active high
- execute  input  1  run request, active high (level)
- tile_mask  input  NUM_TILES  1 = tile participates; 0 = tile treated as halted and quiescent
- timeout_limit  input  CYCLE_COUNTER_WIDTH  run-cycle timeout; 0 = disabled
- tile_halted  input  NUM_TILES  per-tile halted
- tile_channels_quiescent  input  NUM_TILES  per-tile channel quiescence
- tile_routers_quiescent  input  NUM_TILES  per-tile router quiescence
- tile_reset  output  1  active-high reset to tiles
- tile_enable  output  1  enable to tiles
- tile_execute  output  1  execute to tiles
- halted, channels_quiescent, routers_quiescent  output  1 each  reduced status
- done  output  1  run completed normally
- timed_out  output  1  run aborted by timeout
- run_cycles  output  CYCLE_COUNTER_WIDTH  cycles spent in RUN+DRAIN

## Operation
- Input registers: enable and execute are each registered once (enable_q, execute_q). All FSM decisions use the registered values.
- Reductions:
  - r_halted = AND over i of (tile_halted[i] | ~tile_mask[i]); same form for the channel and router inputs.
  - Each reduction passes through REDUCE_STAGES registers; the final stage drives halted / channels_quiescent / routers_quiescent.
  - tile_mask all-zero → all three reductions are 1.
- Distribution: tile_execute = (state==RUN) and tile_enable = enable_q, each delayed by SYNC_STAGES registers. tile_reset is held at 1 while reset is low and propagates through the same pipeline.
- FSM states: IDLE, RUN, DRAIN, DONE, TIMEOUT.
  - IDLE → RUN when enable_q & execute_q. Clear run_cycles, the blanking counter and the hold counter.
  - RUN → DRAIN when the blanking count has expired and the reduced halted = 1.
  - DRAIN → DONE when channels_quiescent & routers_quiescent have been 1 for QUIESCENT_HOLD consecutive cycles. Any 0 clears the hold counter.
  - RUN or DRAIN → TIMEOUT when timeout_limit≠0 and run_cycles+1 ≥ timeout_limit. Timeout has priority over every other transition in the same cycle.
  - DONE or TIMEOUT → IDLE when execute_q = 0.
  - RUN → IDLE when execute_q drops (abort). No done and no timed_out is raised.
- Blanking: after entering RUN, halted is ignored for SYNC_STAGES+REDUCE_STAGES+1 cycles so that stale halted status from the previous run cannot end the new run.
- run_cycles increments every cycle in RUN or DRAIN and saturates at all-ones.
- enable_q = 0 freezes the FSM, run_cycles, the blanking counter and the hold counter. Reductions and distribution pipelines continue to operate.
- done = (state==DONE); timed_out = (state==TIMEOUT). Both are registered outputs.

## Timing
- Reset (reset low at an edge), values after that edge:
  - tile_reset = 1
  - tile_enable = 0, tile_execute = 0
  - halted, channels_quiescent, routers_quiescent = 0
  - done = 0, timed_out = 0, run_cycles = 0
  - state = IDLE; all pipeline registers cleared, except tile_reset stages, which are set.
- tile_reset falls SYNC_STAGES cycles after the first edge with reset high.
- execute high before edge 0 (enable steady high): execute_q at edge 0; RUN at edge 1; tile_execute high after edge 1+SYNC_STAGES.
- Tile status change to reduced output: REDUCE_STAGES cycles.
- Reset mid-run: the FSM returns to IDLE in the same edge and every output takes its reset value.

## Test plan
- Reset, then defaults: hold reset low 3 cycles → tile_reset=1 and all other outputs 0; with SYNC_STAGES=2, tile_reset falls 2 cycles after reset releases.
- Normal run:
  - Setup: NUM_TILES=4, mask=4'hF, timeout 0, execute high.
  - Stimulus: tiles raise halted 20 cycles after tile_execute rises; quiescence already high.
  - Required: DRAIN, then done=1 after QUIESCENT_HOLD=4 cycles; run_cycles is stable from then on; dropping execute returns the FSM to IDLE.
- Masking: mask=4'b0111 with tile 3 never halting → run completes normally. Mask=0 → halted=1 from reset onward.
- Stale halted blanking: all tiles halted=1 at execute rise → FSM stays in RUN for the blanking window (3 cycles with default parameters) before DRAIN.
- Quiescence glitch: in DRAIN, drop routers_quiescent for 1 cycle after 3 good cycles → hold counter restarts and done arrives 4 cycles after recovery.
- Timeout and enable:
  - timeout_limit=10 with tiles never halting → timed_out=1, tile_execute=0, run_cycles=10.
  - Deasserting enable for 5 cycles in RUN → run_cycles frozen for those 5 cycles.
